mem_burst_arbiter: RTL
======================

Name: mem_burst_arbiter

Overview:
- Round-robin burst arbiter that shares one 512x20 two-port RAM (write-priority, 1-cycle registered read) between two clients.
- Each client issues a read or write burst of 1-8 words.
- The arbiter owns the RAM control pins, generates incrementing addresses, paces write data and returns read data with per-client valids.
- Sits directly in front of the RAM instance; clients never touch RAM pins.

Parameters:
- AW, 9, RAM address width (512 words)
- DW, 20, RAM data width
- LW, 3, burst-length field width; beats = len+1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_0 / req_1  in  1  client burst request, held until gnt
- we_0 / we_1  in  1  1=write burst, 0=read burst; stable while req
- addr_0 / addr_1  in  AW  burst start address; stable while req
- len_0 / len_1  in  LW  beats-1; stable while req
- wdata_0 / wdata_1  in  DW  current write word
- gnt_0 / gnt_1  out  1  one-cycle pulse: request accepted
- wnext_0 / wnext_1  out  1  current wdata consumed this cycle; client presents next word by next cycle
- rvalid_0 / rvalid_1  out  1  rdata valid for that client this cycle
- rdata  out  DW  read data (shared), = mem_q
- busy  out  1  burst in progress
- mem_ra  out  AW  RAM read address
- mem_wa  out  AW  RAM write address
- mem_write  out  1  RAM write enable
- mem_d  out  DW  RAM write data
- mem_q  in  DW  RAM read data, registered, valid 1 cycle after read issue

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt, wnext, rvalid, busy, mem_write=0; addr counter=0, so mem_ra=mem_wa=0; beat counter=0; rr pointer last=1 (client 0 preferred next).
- FSM IDLE:
  - If any req, arbitrate and pulse gnt_x for exactly 1 cycle.
  - Latch owner, we, addr, len.
  - Go to BURST next cycle.
- Arbitration: only one req -> grant it; both -> grant the client != last; last updated on grant.
- FSM BURST, one beat per cycle:
  - mem_ra=mem_wa=addr counter.
  - Write burst: mem_write=1, mem_d=wdata_owner (combinational), wnext_owner=1.
  - Read burst: mem_write=0, rvalid_owner=1 on the following cycle, rdata=mem_q.
  - Addr +1 per beat, wrapping 511->0 (mod 2^AW).
  - Beat counter runs 0..len; after beat len -> IDLE.
- Timing:
  - Burst of N beats occupies N cycles after the gnt cycle.
  - Minimum 1 IDLE cycle between bursts (gnt cycle); back-to-back throughput = N/(N+1).
- Read latency: 1 cycle from beat issue to rvalid. The last read rvalid falls in the first IDLE cycle after BURST, and must be produced there.
- Outside write beats mem_write=0. The RAM performs idle reads that are not flagged valid.
- busy=1 exactly while state=BURST.
- Requests arriving during BURST wait; gnt never asserted in BURST.
- req dropped before gnt: no grant, no RAM activity.
- Reset mid-burst: burst aborted immediately. Words already written remain in RAM. No further rvalid, even for a read issued in the reset cycle.
- len=0: single-beat burst, 1 BURST cycle.
- Non-owner client outputs (wnext, rvalid) stay 0.

Optional Feature:
- Macro MEM_BURST_ARB_STATS_EN.
- When defined:
  - Adds outputs beats_0 / beats_1 (16 bits each): count of beats executed per client.
  - Saturate at 0xFFFF; reset to 0 by rst_n.
  - Also adds input stats_clr (1): synchronous clear of both counters. Clear wins over a same-cycle increment.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then req_0, we_0=1, addr_0=0x010, len_0=3, wdata 0xA0001..0xA0004 advanced on wnext -> gnt_0 one cycle; mem_write=1 for 4 cycles at wa 0x010..0x013 with matching mem_d; busy high exactly 4 cycles.
- Same client reads addr 0x010 len 3 -> rvalid_0 on 4 consecutive cycles, starting 2 cycles after gnt_0; rdata 0xA0001..0xA0004; rvalid_1 stays 0.
- Write burst at addr 0x1FE len 3 -> write addresses 0x1FE, 0x1FF, 0x000, 0x001; readback returns the same data.
- req_0 and req_1 held continuously, len=0 each -> grants alternate 0,1,0,1 starting with client 0; each burst separated by 1 gnt cycle.
- rst_n low during beat 2 of an 8-beat write to 0x100 -> mem_write and gnt drop asynchronously; after release, readback of 0x100..0x101 returns new data and 0x102.. keeps old data.
- With MEM_BURST_ARB_STATS_EN: run a 5-beat burst on client 1 -> beats_1=5; pulse stats_clr -> 0; 70000 beats -> saturates at 0xFFFF.

Source files
------------

// File: rtl/mem_burst_arbiter.sv
`timescale 1ns/1ps
// Round-robin burst arbiter giving two clients shared access to a 512x20 two-port RAM.
// Defining MEM_BURST_ARB_STATS_EN adds saturating per-client beat counters with a sync clear.
module mem_burst_arbiter #(
    parameter int AW = 9,
    parameter int DW = 20,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_0,
    input  logic          req_1,
    input  logic          we_0,
    input  logic          we_1,
    input  logic [AW-1:0] addr_0,
    input  logic [AW-1:0] addr_1,
    input  logic [LW-1:0] len_0,
    input  logic [LW-1:0] len_1,
    input  logic [DW-1:0] wdata_0,
    input  logic [DW-1:0] wdata_1,
    output logic          gnt_0,
    output logic          gnt_1,
    output logic          wnext_0,
    output logic          wnext_1,
    output logic          rvalid_0,
    output logic          rvalid_1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_ra,
    output logic [AW-1:0] mem_wa,
    output logic          mem_write,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
`ifdef MEM_BURST_ARB_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [15:0]   beats_0,
    output logic [15:0]   beats_1
`endif
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] beat_q, beat_d;
    logic          last_q, last_d;
    logic          rvld_q, rvld_d;
    logic          rown_q, rown_d;
    logic          sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            last_q  <= 1'b1;
            rvld_q  <= 1'b0;
            rown_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            rvld_q  <= rvld_d;
            rown_q  <= rown_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        last_d    = last_q;
        rvld_d    = 1'b0;
        rown_d    = rown_q;
        sel       = 1'b0;
        gnt_0     = 1'b0;
        gnt_1     = 1'b0;
        wnext_0   = 1'b0;
        wnext_1   = 1'b0;
        mem_write = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_0 || req_1) begin
                    // On contention the client that did not win last time goes first.
                    sel     = (req_0 && req_1) ? ~last_q : req_1;
                    gnt_0   = ~sel;
                    gnt_1   = sel;
                    owner_d = sel;
                    last_d  = sel;
                    we_d    = sel ? we_1 : we_0;
                    addr_d  = sel ? addr_1 : addr_0;
                    len_d   = sel ? len_1 : len_0;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                busy      = 1'b1;
                mem_write = we_q;
                wnext_0   = we_q & ~owner_q;
                wnext_1   = we_q & owner_q;
                rvld_d    = ~we_q;
                rown_d    = owner_q;
                addr_d    = addr_q + 1'b1;
                beat_d    = beat_q + 1'b1;
                if (beat_q == len_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The final read beat's rvalid lands in IDLE, so it is driven from its own register.
    assign rvalid_0 = rvld_q & ~rown_q;
    assign rvalid_1 = rvld_q & rown_q;
    assign rdata    = mem_q;
    assign mem_ra   = addr_q;
    assign mem_wa   = addr_q;
    assign mem_d    = owner_q ? wdata_1 : wdata_0;

`ifdef MEM_BURST_ARB_STATS_EN
    logic [15:0] beats0_q, beats0_d;
    logic [15:0] beats1_q, beats1_d;

    always_comb begin
        beats0_d = beats0_q;
        beats1_d = beats1_q;
        if (stats_clr) begin
            beats0_d = '0;
            beats1_d = '0;
        end else if (state_q == BURST) begin
            if (!owner_q && beats0_q != 16'hFFFF) beats0_d = beats0_q + 16'd1;
            if (owner_q && beats1_q != 16'hFFFF)  beats1_d = beats1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats0_q <= '0;
            beats1_q <= '0;
        end else begin
            beats0_q <= beats0_d;
            beats1_q <= beats1_d;
        end
    end

    assign beats_0 = beats0_q;
    assign beats_1 = beats1_q;
`endif

endmodule
